// File: rtl/sram_pkg.sv
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types and constants for the MEM-stage SRAM port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam int          WA_W              = SRAM_AW - 1;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Below the base, or a word index that does not fit in WA_W bits.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return (addr < base) || (off[31:WA_W+2] != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_mem_stage.sv
// ============================================================================
// Module   : sram_mem_stage
// Brief    : Splits one 32-bit load/store into two 16-bit async-SRAM accesses,
//            freezing the pipeline via ready. Optional SRAM_ADDR_CHECK_EN
//            adds an out-of-range address flag (addr_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_stage
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          HALF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_out,
    input  logic [31:0]        Val_RM,
    output logic               ready,
    output logic [31:0]        read_data,
`ifdef SRAM_ADDR_CHECK_EN
    output logic               addr_err,
`endif
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int             CNT_W    = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

    state_t            r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [WA_W-1:0]   r_wa_q,    w_wa_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic              r_store_q, w_store_d;
    logic [31:0]       r_rdata_q, w_rdata_d;

    logic              w_req;
    logic              w_last;
    logic              w_active;
    logic [31:0]       w_offset;
    logic              w_unused_bits;

`ifdef SRAM_ADDR_CHECK_EN
    logic              r_err_q, w_err_d;
    logic              w_addr_bad;
    assign w_addr_bad = addr_out_of_range(ALU_out, BASE_ADDR);
    assign addr_err   = r_err_q;
`endif

    assign w_req         = MEM_R_EN | MEM_W_EN;
    assign w_last        = (r_cnt_q == CNT_LAST);
    assign w_active      = (r_state_q == LO) || (r_state_q == HI);
    assign w_offset      = ALU_out - BASE_ADDR;
    assign w_unused_bits = ^{w_offset[31:WA_W+2], w_offset[1:0]};

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_wa_d    = r_wa_q;
        w_wdata_d = r_wdata_q;
        w_store_d = r_store_q;
        w_rdata_d = r_rdata_q;
`ifdef SRAM_ADDR_CHECK_EN
        w_err_d   = r_err_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (w_req) begin
                    w_wa_d    = w_offset[WA_W+1:2];
                    w_wdata_d = Val_RM;
                    w_store_d = MEM_W_EN;
                    w_cnt_d   = '0;
`ifdef SRAM_ADDR_CHECK_EN
                    // A bad address skips the bus entirely and reports in DONE.
                    if (w_addr_bad) begin
                        w_state_d = DONE;
                        w_err_d   = 1'b1;
                        if (!MEM_W_EN) begin
                            w_rdata_d = '0;
                        end
                    end else begin
                        w_state_d = LO;
                        w_err_d   = 1'b0;
                    end
`else
                    w_state_d = LO;
`endif
                end
            end
            LO: begin
                if (w_last) begin
                    w_state_d = HI;
                    w_cnt_d   = '0;
                    if (!r_store_q) begin
                        w_rdata_d[15:0] = SRAM_DQ;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            HI: begin
                if (w_last) begin
                    w_state_d = DONE;
                    w_cnt_d   = '0;
                    if (!r_store_q) begin
                        w_rdata_d[31:16] = SRAM_DQ;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_wa_q    <= '0;
            r_wdata_q <= '0;
            r_store_q <= 1'b0;
            r_rdata_q <= '0;
`ifdef SRAM_ADDR_CHECK_EN
            r_err_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_wa_q    <= w_wa_d;
            r_wdata_q <= w_wdata_d;
            r_store_q <= w_store_d;
            r_rdata_q <= w_rdata_d;
`ifdef SRAM_ADDR_CHECK_EN
            r_err_q   <= w_err_d;
`endif
        end
    end

    // Strobes decode straight from the state register so they drop the cycle reset hits.
    assign SRAM_CE_N = !w_active;
    assign SRAM_OE_N = !(w_active && !r_store_q);
    assign SRAM_WE_N = !(w_active && r_store_q);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = {r_wa_q, (r_state_q == HI)};
    assign SRAM_DQ   = (w_active && r_store_q)
                       ? ((r_state_q == HI) ? r_wdata_q[31:16] : r_wdata_q[15:0])
                       : {SRAM_DW{1'bz}};

    assign ready     = !(w_req && (r_state_q != DONE));
    assign read_data = r_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_stage.sv
// ============================================================================
// Module   : tb_sram_mem_stage
// Brief    : Directed self-checking bench for sram_mem_stage with a small
//            behavioural async SRAM. Covers SRAM_ADDR_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_out;
    logic [31:0] val_rm;
    logic        ready;
    logic [31:0] read_data;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_mem_stage #(.BASE_ADDR(32'd1024), .HALF_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (mem_r_en),
        .MEM_W_EN  (mem_w_en),
        .ALU_out   (alu_out),
        .Val_RM    (val_rm),
        .ready     (ready),
        .read_data (read_data),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err  (addr_err),
`endif
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n)
    );

    // Behavioural async SRAM: drives the bus only for a read strobe.
    logic [15:0] mem [0:63];
    wire         tb_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq = tb_drive ? mem[sram_addr[5:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_addr[17:6] == 12'd0)
            mem[sram_addr[5:0]] <= sram_dq;
    end

    // Starts at posedge+1 with the FSM idle; returns at posedge+1 after DONE.
    task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic keep,
                             output int frozen, output logic [31:0] rd,
                             output int n_we, output int n_oe, output int n_ce,
                             output logic [17:0] a_first, output logic [17:0] a_last,
                             output logic err);
        mem_r_en = r; mem_w_en = w; alu_out = a; val_rm = d;
        frozen = 0; n_we = 0; n_oe = 0; n_ce = 0;
        a_first = '1; a_last = '1; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sram_we_n) n_we++;
            if (!sram_oe_n) n_oe++;
            if (!sram_ce_n) begin
                if (n_ce == 0) a_first = sram_addr;
                a_last = sram_addr;
                n_ce++;
            end
            if (ready) break;
            frozen++;
        end
        rd = read_data;
`ifdef SRAM_ADDR_CHECK_EN
        err = addr_err;
`endif
        @(posedge clk); #1;
        if (!keep) begin
            mem_r_en = 1'b0; mem_w_en = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_out = '0; val_rm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if ({sram_ce_n, sram_we_n, sram_oe_n} !== 3'b111) begin failures++; $display("FAIL reset_strobes got=%b exp=111", {sram_ce_n, sram_we_n, sram_oe_n}); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
        checks++; if ({sram_ub_n, sram_lb_n} !== 2'b00) begin failures++; $display("FAIL ub_lb got=%b exp=00", {sram_ub_n, sram_lb_n}); end
`ifdef SRAM_ADDR_CHECK_EN
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
`endif
        mem_r_en = 1'b1; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready_req got=%b exp=0", ready); end
        @(posedge clk); @(negedge clk);
        checks++; if (sram_ce_n !== 1'b1) begin failures++; $display("FAIL reset_hold_ce got=%b exp=1", sram_ce_n); end
        mem_r_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store;
        int fr, nwe, noe, nce; logic [31:0] rd; logic [17:0] af, al; logic er;
        do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 5) begin failures++; $display("FAIL store_frozen got=%0d exp=5", fr); end
        checks++; if (nwe !== 4 || noe !== 0) begin failures++; $display("FAIL store_strobes we=%0d oe=%0d exp we=4 oe=0", nwe, noe); end
        checks++; if (af !== 18'd0 || al !== 18'd1) begin failures++; $display("FAIL store_addr first=%0d last=%0d exp 0/1", af, al); end
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin failures++; $display("FAIL store_mem got=%h_%h exp=DEAD_BEEF", mem[1], mem[0]); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_read_data got=%h exp=0", rd); end
    endtask

    task automatic test_load;
        int fr, nwe, noe, nce; logic [31:0] rd; logic [17:0] af, al; logic er;
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 5) begin failures++; $display("FAIL load_frozen got=%0d exp=5", fr); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", rd); end
        checks++; if (nwe !== 0 || noe !== 4) begin failures++; $display("FAIL load_strobes we=%0d oe=%0d exp we=0 oe=4", nwe, noe); end
        checks++; if (af !== 18'd0 || al !== 18'd1) begin failures++; $display("FAIL load_addr first=%0d last=%0d exp 0/1", af, al); end
    endtask

    task automatic test_back_to_back;
        int fr, nwe, noe, nce, c0; logic [31:0] rd; logic [17:0] af, al; logic er;
        c0 = cyc;
        do_access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b1, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 5) begin failures++; $display("FAIL b2b_store_frozen got=%0d exp=5", fr); end
        checks++; if (af !== 18'd2 || al !== 18'd3) begin failures++; $display("FAIL b2b_store_addr first=%0d last=%0d exp 2/3", af, al); end
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin failures++; $display("FAIL b2b_mem got=%h_%h exp=1234_5678", mem[3], mem[2]); end
        checks++; if (fr !== 5) begin failures++; $display("FAIL b2b_load_frozen got=%0d exp=5", fr); end
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL b2b_load_data got=%h exp=12345678", rd); end
        checks++; if (cyc - c0 !== 12) begin failures++; $display("FAIL b2b_period got=%0d exp=12", cyc - c0); end
    endtask

    task automatic test_reset_mid;
        int fr, nwe, noe, nce; logic [31:0] rd; logic [17:0] af, al; logic er;
        mem_w_en = 1'b1; alu_out = 32'd1032; val_rm = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_addr !== 18'd5 || sram_we_n !== 1'b0) begin failures++; $display("FAIL mid_in_hi addr=%0d we_n=%b exp 5/0", sram_addr, sram_we_n); end
        rst = 1'b1; mem_w_en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if ({sram_ce_n, sram_we_n, sram_oe_n} !== 3'b111) begin failures++; $display("FAIL mid_strobes got=%b exp=111", {sram_ce_n, sram_we_n, sram_oe_n}); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL mid_read_data got=%h exp=0", read_data); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 5 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_reload frozen=%0d data=%h exp 5/deadbeef", fr, rd); end
    endtask

    task automatic test_both_enables;
        int fr, nwe, noe, nce; logic [31:0] rd; logic [17:0] af, al; logic er;
        do_access(1'b1, 1'b1, 32'd1036, 32'h0BADC0DE, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 5) begin failures++; $display("FAIL both_frozen got=%0d exp=5", fr); end
        checks++; if (nwe !== 4 || noe !== 0) begin failures++; $display("FAIL both_strobes we=%0d oe=%0d exp we=4 oe=0", nwe, noe); end
        checks++; if (mem[6] !== 16'hC0DE || mem[7] !== 16'h0BAD) begin failures++; $display("FAIL both_mem got=%h_%h exp=0bad_c0de", mem[7], mem[6]); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL both_read_data got=%h exp=deadbeef", rd); end
    endtask

`ifdef SRAM_ADDR_CHECK_EN
    task automatic test_addr_check;
        int fr, nwe, noe, nce; logic [31:0] rd; logic [17:0] af, al; logic er;
        do_access(1'b1, 1'b0, 32'd512, 32'h0, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (fr !== 1) begin failures++; $display("FAIL err_frozen got=%0d exp=1", fr); end
        checks++; if (nce !== 0) begin failures++; $display("FAIL err_ce got=%0d exp=0", nce); end
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_read_data got=%h exp=0", rd); end
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, fr, rd, nwe, noe, nce, af, al, er);
        checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_recover flag=%b data=%h exp 0/deadbeef", er, rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_both_enables();
`ifdef SRAM_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
